// File: rtl/adder_result_fifo.sv
// rtl/adder_result_fifo.sv - result checker and FIFO for ripple adder beats
module adder_result_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int ERR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_cin,
    input  logic [WIDTH-1:0]         in_sum,
    input  logic                     in_cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic                     out_cin,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_cout,
    output logic                     out_err,
    output logic [ERR_W-1:0]         err_count,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 3 * WIDTH + 3;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [ERR_W-1:0] r_err_count;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH:0]   w_exp;
    logic             w_err;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;

    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Reference sum is one bit wider so the carry-out is checked as well
    assign w_exp   = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
    assign w_err   = ({in_cout, in_sum} != w_exp);
    assign w_entry = {in_a, in_b, in_cin, in_sum, in_cout, w_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    // Storage holds no reset; stale contents are masked by out_valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

    always_comb begin
        out_a    = w_head[EW-1 -: WIDTH];
        out_b    = w_head[EW-1-WIDTH -: WIDTH];
        out_cin  = w_head[WIDTH+2];
        out_sum  = w_head[WIDTH+1 -: WIDTH];
        out_cout = w_head[1];
        out_err  = w_head[0];
    end

    assign err_count = r_err_count;
    assign count     = r_count;

endmodule
